// File: rtl/seq_mult_ctrl_pkg.sv
// seq_mult_ctrl_pkg: shared state encoding and default operand width
package seq_mult_ctrl_pkg;
   localparam int WIDTH_DEF = 32;
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      ADD  = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;
endpackage

// File: rtl/seq_mult_ctrl_sign_mag.sv
// seq_mult_ctrl_sign_mag: splits a two's complement value into sign and unsigned magnitude
module seq_mult_ctrl_sign_mag
   import seq_mult_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] val,
   output logic             sign,
   output logic [WIDTH-1:0] mag
);
   logic [WIDTH:0] ext;
   logic [WIDTH:0] full;
   assign sign = val[WIDTH-1];
   assign ext  = {sign, val};
   assign full = sign ? -ext : ext;
   // |-2^(WIDTH-1)| = 2^(WIDTH-1) still fits in WIDTH unsigned bits, so bit WIDTH is always 0
   assign mag  = full[WIDTH-1:0] | {WIDTH{full[WIDTH] & 1'b0}};
endmodule

// File: rtl/seq_mult_ctrl.sv
// seq_mult_ctrl: signed repeated-addition multiplier; SEQ_MULT_ZERO_SKIP_EN enables the zero-operand shortcut
module seq_mult_ctrl
   import seq_mult_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [WIDTH-1:0]   data1,
   input  logic [WIDTH-1:0]   data2,
   output logic               busy,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic               cnt_zero
);
   localparam int PW = 2 * WIDTH;
   localparam logic [WIDTH-1:0] ONE = 1;
   state_t state_q, state_d;
   logic [WIDTH-1:0] op1_q, op1_d, op2_q, op2_d, mag_a_q, mag_a_d, cnt_q, cnt_d;
   logic [PW-1:0] acc_q, acc_d, product_q, product_d;
   logic neg_q, neg_d, s1, s2;
   logic [WIDTH-1:0] m1, m2;
   seq_mult_ctrl_sign_mag #(.WIDTH(WIDTH)) u_sm1 (.val(op1_q), .sign(s1), .mag(m1));
   seq_mult_ctrl_sign_mag #(.WIDTH(WIDTH)) u_sm2 (.val(op2_q), .sign(s2), .mag(m2));
   assign busy     = state_q == LOAD || state_q == ADD || state_q == FIX;
   assign done     = state_q == DONE;
   assign product  = product_q;
   assign cnt_zero = cnt_q == '0;
   // next-state and datapath updates; start is only honoured in IDLE and DONE
   always_comb begin
      state_d   = state_q;
      op1_d     = op1_q;
      op2_d     = op2_q;
      mag_a_d   = mag_a_q;
      neg_d     = neg_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      product_d = product_q;
      case (state_q)
         IDLE, DONE: begin
            state_d = start ? LOAD : IDLE;
            if (start) begin
               op1_d = data1;
               op2_d = data2;
            end
         end
         LOAD: begin
            mag_a_d = m1;
            neg_d   = s1 ^ s2;
            acc_d   = '0;
            cnt_d   = m2;
            state_d = ADD;
`ifdef SEQ_MULT_ZERO_SKIP_EN
            if (m1 == '0 || m2 == '0) begin
               product_d = '0;
               state_d   = DONE;
            end
`endif
         end
         ADD: begin
            state_d = cnt_zero ? FIX : ADD;
            if (!cnt_zero) begin
               acc_d = acc_q + {{WIDTH{1'b0}}, mag_a_q};
               cnt_d = cnt_q - ONE;
            end
         end
         FIX: begin
            product_d = (neg_q && acc_q != '0) ? -acc_q : acc_q;
            state_d   = DONE;
         end
         default: state_d = IDLE;
      endcase
   end
   // state and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         op1_q     <= '0;
         op2_q     <= '0;
         mag_a_q   <= '0;
         neg_q     <= 1'b0;
         acc_q     <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         op1_q     <= op1_d;
         op2_q     <= op2_d;
         mag_a_q   <= mag_a_d;
         neg_q     <= neg_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         product_q <= product_d;
      end
   end
endmodule

// File: tb/tb_seq_mult_ctrl.sv
// tb_seq_mult_ctrl: scoreboard bench for seq_mult_ctrl (32-bit and 8-bit instances)
module tb_seq_mult_ctrl;
   typedef struct {
      logic [63:0] p;
      int          t;
      string       n;
   } exp_t;
`ifdef SEQ_MULT_ZERO_SKIP_EN
   localparam int L0A = 2;
   localparam int L0B = 2;
`else
   localparam int L0A = 9;
   localparam int L0B = 4;
`endif
   logic clk = 0, rst = 1, start = 0, start8 = 0;
   logic [31:0] d1 = 0, d2 = 0;
   logic [7:0] e1 = 0, e2 = 0;
   logic busy, done, cz, busy8, done8, cz8;
   logic [63:0] product;
   logic [15:0] product8;
   int checks = 0, errors = 0, cyc = 0;
   exp_t q[$], q8[$];

   seq_mult_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .data1(d1), .data2(d2),
      .busy(busy), .done(done), .product(product), .cnt_zero(cz)
   );
   seq_mult_ctrl #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .data1(e1), .data2(e2),
      .busy(busy8), .done(done8), .product(product8), .cnt_zero(cz8)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string n, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", n, act, exp);
      end
   endtask

   task automatic miss(input string n);
      checks++;
      errors++;
      $display("FAIL %s: no done within cycle budget", n);
   endtask

   always @(negedge clk) begin
      if (!rst && done) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got product %0h expected no done", product);
         end else begin
            exp_t e;
            e = q.pop_front();
            check({e.n, "_product"}, product, e.p);
            check({e.n, "_cycle"}, 64'(cyc), 64'(e.t));
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && done8) begin
         if (q8.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done8: got product %0h expected no done", product8);
         end else begin
            exp_t e;
            e = q8.pop_front();
            check({e.n, "_product"}, {48'b0, product8}, e.p);
            check({e.n, "_cycle"}, 64'(cyc), 64'(e.t));
         end
      end
   end

   task automatic run(input logic [31:0] a, input logic [31:0] b, input logic [63:0] p,
                      input int lat, input string n);
      int bc = 0;
      int k = 0;
      @(negedge clk);
      d1 = a;
      d2 = b;
      start = 1;
      q.push_back('{p, cyc + lat, n});
      while (q.size() != 0 && k < lat + 20) begin
         @(negedge clk);
         start = 0;
         #1;
         bc += int'(busy);
         k++;
      end
      if (q.size() != 0) begin
         miss(n);
         q.delete();
      end else check({n, "_busy_cycles"}, 64'(bc), 64'(lat - 1));
   endtask

   initial begin
      int k;
      repeat (2) @(negedge clk);
      check("rst_busy", {63'b0, busy}, 64'd0);
      check("rst_done", {63'b0, done}, 64'd0);
      check("rst_product", product, 64'd0);
      check("rst_cnt_zero", {63'b0, cz}, 64'd1);
      check("rst_product8", {48'b0, product8}, 64'd0);
      rst = 0;
      run(32'd7, 32'd5, 64'd35, 9, "7x5");
      run(-32'sd6, 32'd4, -64'sd24, 8, "n6x4");
      run(32'd6, -32'sd4, -64'sd24, 8, "6xn4");
      run(-32'sd6, -32'sd4, 64'd24, 8, "n6xn4");
      run(32'd0, 32'd5, 64'd0, L0A, "0x5");
      run(32'd9, 32'd0, 64'd0, L0B, "9x0");
      run(32'h8000_0000, 32'd3, -64'sd6442450944, 7, "minx3");
      @(negedge clk);
      d1 = 5;
      d2 = 5;
      start = 1;
      q.push_back('{64'd25, cyc + 9, "b2b1"});
      q.push_back('{64'd6, cyc + 16, "b2b2"});
      @(negedge clk);
      d1 = 2;
      d2 = 3;
      k = 0;
      while (q.size() != 0 && k < 40) begin
         @(negedge clk);
         if (k == 10) start = 0;
         #1;
         k++;
      end
      start = 0;
      if (q.size() != 0) begin
         miss("b2b");
         q.delete();
      end
      @(negedge clk);
      d1 = 3;
      d2 = 10;
      start = 1;
      @(negedge clk);
      start = 0;
      repeat (4) @(negedge clk);
      check("pre_rst_busy", {63'b0, busy}, 64'd1);
      rst = 1;
      @(negedge clk);
      rst = 0;
      #1;
      check("mid_rst_busy", {63'b0, busy}, 64'd0);
      check("mid_rst_done", {63'b0, done}, 64'd0);
      check("mid_rst_product", product, 64'd0);
      check("mid_rst_cnt_zero", {63'b0, cz}, 64'd1);
      repeat (20) @(negedge clk);
      run(32'd4, 32'd4, 64'd16, 8, "4x4");
      @(negedge clk);
      e1 = 8'd3;
      e2 = 8'h80;
      start8 = 1;
      q8.push_back('{64'h0000_0000_0000_FE80, cyc + 132, "w8_3xmin"});
      k = 0;
      while (q8.size() != 0 && k < 200) begin
         @(negedge clk);
         start8 = 0;
         #1;
         k++;
      end
      if (q8.size() != 0) begin
         miss("w8_3xmin");
         q8.delete();
      end
      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
